// File: rtl/return_addr_stack_if.sv
// Bus bundle between the fetch front end (master) and the return-address stack (slave).
// Checkpoint width follows RAS_TOP_REPAIR_EN exactly as the stack itself does.
interface return_addr_stack_if #(
  parameter int STACK_DEPTH = 16,
  parameter int ENTRY_SIZE  = 64
);
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
`ifdef RAS_TOP_REPAIR_EN
  localparam int CKPT_W = PTR_W + CNT_W + ENTRY_SIZE;
`else
  localparam int CKPT_W = PTR_W + CNT_W;
`endif

  logic                  push_in;
  logic                  pop_in;
  logic [ENTRY_SIZE-1:0] push_data_in;
  logic                  restore_in;
  logic [CKPT_W-1:0]     restore_ckpt_in;
  logic [ENTRY_SIZE-1:0] top_out;
  logic                  top_valid_out;
  logic [CNT_W-1:0]      count_out;
  logic [CKPT_W-1:0]     ckpt_out;
  logic                  overflow_out;
  logic                  underflow_out;

  modport master (
    output push_in, pop_in, push_data_in, restore_in, restore_ckpt_in,
    input  top_out, top_valid_out, count_out, ckpt_out, overflow_out, underflow_out
  );

  modport slave (
    input  push_in, pop_in, push_data_in, restore_in, restore_ckpt_in,
    output top_out, top_valid_out, count_out, ckpt_out, overflow_out, underflow_out
  );
endinterface

// File: rtl/return_addr_stack.sv
// Circular return-address stack with occupancy tracking, overflow/underflow pulses and
// one-cycle checkpoint restore. Define RAS_TOP_REPAIR_EN to carry and repair the top entry.
module return_addr_stack #(
  parameter int STACK_DEPTH = 16,
  parameter int ENTRY_SIZE  = 64
) (
  input  logic               clk_in,
  input  logic               rst_in,
  return_addr_stack_if.slave ras
);
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
`ifdef RAS_TOP_REPAIR_EN
  localparam int CKPT_W = PTR_W + CNT_W + ENTRY_SIZE;
`else
  localparam int CKPT_W = PTR_W + CNT_W;
`endif
  localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic [ENTRY_SIZE-1:0] r_mem [STACK_DEPTH];
  logic                  r_overflow;
  logic                  r_underflow;

  logic [PTR_W-1:0]      w_tailNext;
  logic [CNT_W-1:0]      w_countNext;
  logic                  w_overflowNext;
  logic                  w_underflowNext;
  logic                  w_memWe;
  logic [PTR_W-1:0]      w_memAddr;
  logic [ENTRY_SIZE-1:0] w_memData;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_ckptCount;
  logic [PTR_W-1:0]      w_ckptTail;

  assign w_empty     = (r_count == '0);
  assign w_ckptCount = ras.restore_ckpt_in[CKPT_W-1 -: CNT_W];
  assign w_ckptTail  = ras.restore_ckpt_in[CKPT_W-CNT_W-1 -: PTR_W];

  always_comb begin
    w_tailNext      = r_tail;
    w_countNext     = r_count;
    w_overflowNext  = 1'b0;
    w_underflowNext = 1'b0;
    w_memWe         = 1'b0;
    w_memAddr       = r_tail;
    w_memData       = ras.push_data_in;
    if (ras.restore_in) begin
      w_tailNext  = w_ckptTail;
      w_countNext = w_ckptCount;
`ifdef RAS_TOP_REPAIR_EN
      w_memWe     = 1'b1;
      w_memAddr   = w_ckptTail;
      w_memData   = ras.restore_ckpt_in[ENTRY_SIZE-1:0];
`endif
    end else if (ras.push_in && ras.pop_in && !w_empty) begin
      w_memWe = 1'b1;
    end else if (ras.push_in) begin
      // Also covers push+pop on an empty stack, which degenerates to a plain push.
      w_tailNext     = r_tail + 1'b1;
      w_memWe        = 1'b1;
      w_memAddr      = r_tail + 1'b1;
      w_countNext    = (r_count == FULL) ? FULL : r_count + 1'b1;
      w_overflowNext = (r_count == FULL);
    end else if (ras.pop_in) begin
      if (w_empty) begin
        w_underflowNext = 1'b1;
      end else begin
        w_tailNext  = r_tail - 1'b1;
        w_countNext = r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_tail      <= w_tailNext;
      r_count     <= w_countNext;
      r_overflow  <= w_overflowNext;
      r_underflow <= w_underflowNext;
    end
  end

  // Storage is deliberately unreset; count alone decides what is reachable.
  always_ff @(posedge clk_in) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memData;
    end
  end

  assign ras.top_out       = r_mem[r_tail];
  assign ras.top_valid_out = !w_empty;
  assign ras.count_out     = r_count;
  assign ras.overflow_out  = r_overflow;
  assign ras.underflow_out = r_underflow;
`ifdef RAS_TOP_REPAIR_EN
  assign ras.ckpt_out      = {r_count, r_tail, r_mem[r_tail]};
`else
  assign ras.ckpt_out      = {r_count, r_tail};
`endif
endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack (depth 4, 16-bit entries): a directed vector
// table followed by hand-written restore and asynchronous-reset sequences.
module tb_return_addr_stack;
  localparam int DEPTH = 4;
  localparam int ESZ   = 16;
  localparam int PTR_W = 2;
  localparam int CNT_W = 3;
`ifdef RAS_TOP_REPAIR_EN
  localparam int CKPT_W = PTR_W + CNT_W + ESZ;
`else
  localparam int CKPT_W = PTR_W + CNT_W;
`endif

  typedef struct {
    logic            push;
    logic            pop;
    logic [ESZ-1:0]  data;
    int              expCount;
    logic            checkTop;
    logic [ESZ-1:0]  expTop;
    logic            expOvf;
    logic            expUnf;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   testsRun = 0;
  int   testsFailed = 0;
  vec_t vecs[$];
  logic [CKPT_W-1:0] savedCkpt;
  logic [CKPT_W-1:0] expCkpt;

  return_addr_stack_if #(.STACK_DEPTH(DEPTH), .ENTRY_SIZE(ESZ)) ras ();

  return_addr_stack #(.STACK_DEPTH(DEPTH), .ENTRY_SIZE(ESZ)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .ras    (ras)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic push, logic pop, logic [ESZ-1:0] data, int expCount,
                              logic checkTop, logic [ESZ-1:0] expTop, logic expOvf, logic expUnf);
    vec_t v;
    v.push = push; v.pop = pop; v.data = data; v.expCount = expCount;
    v.checkTop = checkTop; v.expTop = expTop; v.expOvf = expOvf; v.expUnf = expUnf;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic push, input logic pop, input logic [ESZ-1:0] data,
                               input logic restore, input logic [CKPT_W-1:0] ckpt);
    @(negedge clk);
    ras.push_in = push;
    ras.pop_in = pop;
    ras.push_data_in = data;
    ras.restore_in = restore;
    ras.restore_ckpt_in = ckpt;
    @(posedge clk);
    #1;
    ras.push_in = 1'b0;
    ras.pop_in = 1'b0;
    ras.restore_in = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int expCount, input logic checkTop,
                             input logic [ESZ-1:0] expTop, input logic expOvf, input logic expUnf);
    check({tag, " count"}, 64'(ras.count_out), 64'(expCount));
    check({tag, " valid"}, 64'(ras.top_valid_out), 64'(expCount != 0));
    check({tag, " overflow"}, 64'(ras.overflow_out), 64'(expOvf));
    check({tag, " underflow"}, 64'(ras.underflow_out), 64'(expUnf));
    if (checkTop) check({tag, " top"}, 64'(ras.top_out), 64'(expTop));
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    ras.push_in = 1'b0;
    ras.pop_in = 1'b0;
    ras.push_data_in = '0;
    ras.restore_in = 1'b0;
    ras.restore_ckpt_in = '0;

    // Push/pop basics, empty-stack corner cases, overflow wrap, replace-top.
    vecs.push_back(mk(1, 0, 16'h000A, 1, 1, 16'h000A, 0, 0));
    vecs.push_back(mk(1, 0, 16'h000B, 2, 1, 16'h000B, 0, 0));
    vecs.push_back(mk(1, 0, 16'h000C, 3, 1, 16'h000C, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 2, 1, 16'h000B, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 1, 1, 16'h000A, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0005, 1, 1, 16'h0005, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0001, 1, 1, 16'h0001, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0002, 2, 1, 16'h0002, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0003, 3, 1, 16'h0003, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0004, 4, 1, 16'h0004, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0005, 4, 1, 16'h0005, 1, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 3, 1, 16'h0004, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 2, 1, 16'h0003, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 1, 1, 16'h0002, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 0, 0, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0010, 1, 1, 16'h0010, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0020, 2, 1, 16'h0020, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0030, 2, 1, 16'h0030, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0000, 1, 1, 16'h0010, 0, 0));

    doReset();
    #1;
    checkOutput("reset", 0, 0, 16'h0, 0, 0);
    check("reset ckpt", 64'(ras.ckpt_out[CKPT_W-1 -: CNT_W+PTR_W]), 64'd0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].push, vecs[i].pop, vecs[i].data, 1'b0, '0);
      checkOutput($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].checkTop,
                  vecs[i].expTop, vecs[i].expOvf, vecs[i].expUnf);
    end

    // Checkpoint/restore: wrong-path pop and push are undone; push is ignored during restore.
    doReset();
    applyStimulus(1, 0, 16'h0010, 0, '0);
    applyStimulus(1, 0, 16'h0020, 0, '0);
    savedCkpt = ras.ckpt_out;
`ifdef RAS_TOP_REPAIR_EN
    expCkpt = {3'd2, 2'd2, 16'h0020};
`else
    expCkpt = {3'd2, 2'd2};
`endif
    check("ckpt value", 64'(savedCkpt), 64'(expCkpt));
    applyStimulus(0, 1, 16'h0000, 0, '0);
    checkOutput("wrongpath pop", 1, 1, 16'h0010, 0, 0);
    applyStimulus(1, 0, 16'h0099, 0, '0);
    checkOutput("wrongpath push", 2, 1, 16'h0099, 0, 0);
    applyStimulus(1, 0, 16'h0077, 1, savedCkpt);
`ifdef RAS_TOP_REPAIR_EN
    checkOutput("restore", 2, 1, 16'h0020, 0, 0);
`else
    checkOutput("restore", 2, 1, 16'h0099, 0, 0);
`endif
    applyStimulus(0, 1, 16'h0000, 0, '0);
    checkOutput("pop after restore", 1, 1, 16'h0010, 0, 0);

    // Asynchronous reset between edges, once mid-push and once while overflow is high.
    applyStimulus(1, 0, 16'h0041, 0, '0);
    applyStimulus(1, 0, 16'h0042, 0, '0);
    applyStimulus(1, 0, 16'h0043, 0, '0);
    applyStimulus(1, 0, 16'h0044, 0, '0);
    checkOutput("overflow pulse", 4, 1, 16'h0044, 1, 0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset flags", 0, 0, 16'h0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 0, 16'h0051, 0, '0);
    @(negedge clk);
    ras.push_in = 1'b1;
    ras.push_data_in = 16'h0052;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset midpush", 0, 0, 16'h0, 0, 0);
    ras.push_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 16'h0000, 0, '0);
    checkOutput("after reset idle", 0, 0, 16'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/return_addr_stack.md
# return_addr_stack

Parametrised circular return-address stack for the fetch/branch-prediction front end. It supports push, pop and push+pop (replace top), and wraps around on overflow by overwriting the oldest entry. A speculation checkpoint is exported every cycle, and the stack can be restored from a saved checkpoint in one cycle on a misprediction. It succeeds the single-pointer stack with explicit occupancy tracking, overflow/underflow reporting and optional top-entry repair.

## Interface
- STACK_DEPTH, 16, number of entries; power of two, ≥ 2
- ENTRY_SIZE, 64, width of one entry (return address)
- PTR_W (local), $clog2(STACK_DEPTH), tail pointer width
- CNT_W (local), $clog2(STACK_DEPTH)+1, occupancy width
- CKPT_W (local), PTR_W+CNT_W, plus ENTRY_SIZE when RAS_TOP_REPAIR_EN is defined
- clk_in  in  1  clock; all state updates on rising edge
- rst_in  in  1  asynchronous, active-high reset
- push_in  in  1  push push_data_in this cycle
- pop_in  in  1  pop top entry this cycle
- push_data_in  in  ENTRY_SIZE  data to push
- restore_in  in  1  load state from restore_ckpt_in; highest priority
- restore_ckpt_in  in  CKPT_W  previously captured ckpt_out value
- top_out  out  ENTRY_SIZE  current top entry (mem[tail])
- top_valid_out  out  1  count != 0
- count_out  out  CNT_W  current occupancy, 0..STACK_DEPTH
- ckpt_out  out  CKPT_W  {count, tail[, mem[tail]]}, current (pre-update) state
- overflow_out  out  1  one-cycle pulse: last cycle's push overwrote the oldest entry
- underflow_out  out  1  one-cycle pulse: last cycle's pop found the stack empty

## Operation
- State: tail (PTR_W), count (CNT_W), mem[STACK_DEPTH] (not reset), overflow/underflow flops.
- Priority per cycle: restore_in > push+pop > push > pop > idle.
- Restore: tail, count ← restore_ckpt_in fields; push_in/pop_in ignored that cycle; no flags raised.
- Push only: tail ← tail+1 mod STACK_DEPTH; mem[tail+1] ← push_data_in; count ← min(count+1, STACK_DEPTH). If count == STACK_DEPTH before the push, overflow_out = 1 next cycle.
- Pop only:
  - count > 0: tail ← tail−1 mod STACK_DEPTH; count ← count−1; mem unchanged.
  - count == 0: no state change; underflow_out = 1 next cycle.
- Push+pop, count > 0: mem[tail] ← push_data_in; tail and count unchanged.
- Push+pop, count == 0: behaves as push only (count becomes 1); no underflow.
- top_out, top_valid_out, count_out and ckpt_out are combinational from registered state.
- Popped entries are not cleared. A restore that raises count re-exposes the older entries still in mem.

## Timing
- Reset (async assert, sync-to-clock deassert at the consumer): tail=0, count=0, top_valid_out=0, count_out=0, overflow_out=0, underflow_out=0. top_out is don't-care while top_valid_out=0.
- Latency: an operation presented in cycle N is visible on top_out/count_out/ckpt_out in cycle N+1. overflow_out/underflow_out also assert in N+1, for exactly one cycle.
- ckpt_out in cycle N describes the state before cycle N's operation. Capture it alongside a predicted call/return so restore undoes that op.
- Back-to-back operations are legal every cycle; there is no stall or ready signal.
- Wrap-around: the pointer wraps modulo STACK_DEPTH in both directions. count saturates at STACK_DEPTH and never wraps.
- Reset asserted mid-operation discards the in-flight operation. Memory contents are retained but unreachable (count=0).

## Configuration
- RAS_TOP_REPAIR_EN defined:
  - ckpt_out additionally carries mem[tail] in its LSBs (CKPT_W = PTR_W+CNT_W+ENTRY_SIZE).
  - On restore, mem[ckpt.tail] ← ckpt.top, repairing a top entry clobbered by a wrong-path push.
- RAS_TOP_REPAIR_EN undefined:
  - ckpt_out = {count, tail} only.
  - Restore updates pointers only; mem is never written on restore.

## Test plan
- Reset, then push 0xA, 0xB, 0xC (STACK_DEPTH=4) → count_out 3, top_out 0xC; pop → top_out 0xB, count_out 2.
- Empty stack, pop → underflow_out=1 for one cycle; count_out stays 0, top_valid_out 0. Push+pop of 0x5 when empty → count_out 1, top_out 0x5.
- STACK_DEPTH=4, push 1,2,3,4,5 → overflow_out pulses after the 5th push, count_out 4; four pops return 5,4,3,2; a fifth pop raises underflow.
- Push 0x10, 0x20, then push+pop 0x30 → top_out 0x30, count_out 2; pop → 0x10.
- Push 0x10, 0x20; capture ckpt_out; pop, then push 0x99; restore captured ckpt → count_out 2. Top_out is 0x20 with RAS_TOP_REPAIR_EN defined, and 0x99 without it.
- Assert rst_in asynchronously mid-push (between edges) → count_out=0, flags 0 immediately, with no clock edge required.
